mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ifu_req_valid  input  1  fetch read request.
REQ-005 SHALL have port ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-006 SHALL have port ifu_addr  input  WIDTH  fetch address.
REQ-007 SHALL have port ifu_resp_valid  output  1  one-cycle fetch response pulse.
REQ-008 SHALL have port ifu_rdata  output  WIDTH  fetch read data.
REQ-009 SHALL have port lsu_req_valid  input  1  load/store request.
REQ-010 SHALL have port lsu_req_ready  output  1  load/store request accepted this cycle.
REQ-011 SHALL have port lsu_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port lsu_mem_op  input  3  access size/sign code, passed through.
REQ-013 SHALL have port lsu_addr  input  WIDTH  load/store address.
REQ-014 SHALL have port lsu_wdata  input  WIDTH  store data.
REQ-015 SHALL have port lsu_resp_valid  output  1  one-cycle load data / store ack pulse.
REQ-016 SHALL have port lsu_rdata  output  WIDTH  load data.
REQ-017 SHALL have port mem_req_valid  output  1  request to shared memory port.
REQ-018 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-019 SHALL have ports mem_we (1), mem_op (3), mem_addr (WIDTH), mem_wdata (WIDTH), all outputs, driven from latched request.
REQ-020 SHALL have port mem_resp_valid  input  1  memory response strobe.
REQ-021 SHALL have port mem_rdata  input  WIDTH  memory read data, valid with mem_resp_valid.

Function
REQ-022 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; at most one transaction outstanding.
REQ-023 In IDLE with any request valid, SHALL grant one requester, assert its req_ready combinationally that cycle, latch we/op/addr/wdata, go to ISSUE.
REQ-024 Arbitration SHALL be round-robin: single requester always wins; if both valid, winner is the one not granted last; last-grant flag resets to LSU (IFU wins first tie).
REQ-025 IFU grants SHALL latch we=0, op=3'b010 (word), wdata=0.
REQ-026 req_ready SHALL be 0 in ISSUE and WAIT; requesters hold valid and fields until ready.
REQ-027 In ISSUE SHALL hold mem_req_valid=1 with stable fields until mem_req_ready=1, then go to WAIT; mem_req_valid=0 in IDLE/WAIT.
REQ-028 In WAIT, on mem_resp_valid SHALL register mem_rdata into the granted side's rdata, pulse its resp_valid exactly one cycle later, go to IDLE.
REQ-029 Stores SHALL also receive lsu_resp_valid; lsu_rdata then holds captured mem_rdata, content unspecified.
REQ-030 mem_resp_valid in IDLE or ISSUE SHALL be ignored.
REQ-031 Minimum latency: accept cycle 0, mem_req_valid cycle 1, resp pulse cycle 3 when memory is ready and responds next cycle.
REQ-032 A new request SHALL be accepted in the same cycle the previous resp_valid pulses (FSM already in IDLE).
REQ-033 rdata outputs SHALL hold last value until next response for that side.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, all valid/ready outputs 0, rdata and latched fields 0, last-grant = LSU; an in-flight transaction is dropped without response.
REQ-035 After rst_n rises, first acceptance SHALL occur no earlier than the next rising edge.

Structure
REQ-036 FSM state enum and IFU default op constant (3'b010) SHALL live in the shared package.
REQ-037 Round-robin grant logic SHALL be one sub-module, rr_arb2; rest is flat.

Verification
REQ-038 IFU-only read addr 0x80000000, memory ready immediately, rdata 0x00000413 -> ifu_resp_valid cycle 3, ifu_rdata=0x00000413, mem_op=3'b010.
REQ-039 Both valid after reset, then both again -> IFU served first, LSU second; lsu_req_ready never asserted during IFU's ISSUE/WAIT.
REQ-040 LSU store addr 0x80001000 wdata 0xDEADBEEF op 3'b010, mem_req_ready low 3 cycles -> fields stable throughout, single ack pulse.
REQ-041 Spurious mem_resp_valid in IDLE -> no resp_valid pulse on either side.
REQ-042 rst_n asserted during WAIT -> all outputs 0 immediately; late mem_resp_valid after reset produces no pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state type and fetch access constants for the memory arbiter
package mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   localparam logic [2:0] IFU_OP = 3'b010;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and shared memory port signals of the arbiter
interface mem_arbiter_if #(parameter int WIDTH = 32);
   logic             ifu_req_valid;
   logic             ifu_req_ready;
   logic [WIDTH-1:0] ifu_addr;
   logic             ifu_resp_valid;
   logic [WIDTH-1:0] ifu_rdata;
   logic             lsu_req_valid;
   logic             lsu_req_ready;
   logic             lsu_we;
   logic [2:0]       lsu_mem_op;
   logic [WIDTH-1:0] lsu_addr;
   logic [WIDTH-1:0] lsu_wdata;
   logic             lsu_resp_valid;
   logic [WIDTH-1:0] lsu_rdata;
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic             mem_we;
   logic [2:0]       mem_op;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_resp_valid;
   logic [WIDTH-1:0] mem_rdata;
   modport slave (
      input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_we, lsu_mem_op, lsu_addr, lsu_wdata,
             mem_req_ready, mem_resp_valid, mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
             mem_req_valid, mem_we, mem_op, mem_addr, mem_wdata
   );
   modport master (
      output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_we, lsu_mem_op, lsu_addr, lsu_wdata,
             mem_req_ready, mem_resp_valid, mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
             mem_req_valid, mem_we, mem_op, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; bit 0 = fetch, bit 1 = load/store
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic last_lsu;
   assign gnt[0] = en & req[0] & (~req[1] | last_lsu);
   assign gnt[1] = en & req[1] & ~gnt[0];
   // remember who won last so a tie goes to the other side; reset favours fetch first
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_lsu <= 1'b1;
      else if (|gnt) last_lsu <= gnt[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction in flight
module mem_arbiter #(parameter int WIDTH = 32) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   import mem_arbiter_pkg::*;
   state_t           state;
   logic [1:0]       gnt;
   logic             lsu_sel, mem_we_q, ifu_resp_q, lsu_resp_q;
   logic [2:0]       mem_op_q;
   logic [WIDTH-1:0] addr_q, wdata_q, ifu_rdata_q, lsu_rdata_q;
   rr_arb2 u_arb (
      .clk(clk),
      .rst_n(rst_n),
      .en(rst_n && state == IDLE),
      .req({bus.lsu_req_valid, bus.ifu_req_valid}),
      .gnt(gnt)
   );
   assign bus.ifu_req_ready  = gnt[0];
   assign bus.lsu_req_ready  = gnt[1];
   assign bus.mem_req_valid  = state == ISSUE;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_op         = mem_op_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.ifu_resp_valid = ifu_resp_q;
   assign bus.ifu_rdata      = ifu_rdata_q;
   assign bus.lsu_resp_valid = lsu_resp_q;
   assign bus.lsu_rdata      = lsu_rdata_q;
   // accept -> present to memory -> await response; fetch requests latch as word reads
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         lsu_sel     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_op_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
         ifu_resp_q  <= 1'b0;
         lsu_resp_q  <= 1'b0;
      end else begin
         ifu_resp_q <= 1'b0;
         lsu_resp_q <= 1'b0;
         case (state)
            IDLE: if (|gnt) begin
               lsu_sel  <= gnt[1];
               mem_we_q <= gnt[1] & bus.lsu_we;
               mem_op_q <= gnt[1] ? bus.lsu_mem_op : IFU_OP;
               addr_q   <= gnt[1] ? bus.lsu_addr : bus.ifu_addr;
               wdata_q  <= gnt[1] ? bus.lsu_wdata : '0;
               state    <= ISSUE;
            end
            ISSUE: if (bus.mem_req_ready) state <= WAIT;
            WAIT: if (bus.mem_resp_valid) begin
               if (lsu_sel) begin
                  lsu_rdata_q <= bus.mem_rdata;
                  lsu_resp_q  <= 1'b1;
               end else begin
                  ifu_rdata_q <= bus.mem_rdata;
                  ifu_resp_q  <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for the fetch/load-store memory arbiter
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   mem_arbiter_if #(.WIDTH(32)) bus();
   mem_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.ifu_req_valid = 0; bus.ifu_addr = 0;
      bus.lsu_req_valid = 0; bus.lsu_we = 0; bus.lsu_mem_op = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0;
      bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h100; bus.lsu_req_valid = 1; bus.lsu_addr = 32'h200;
      @(negedge clk); #1;
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid}); end
      checks++; if ({bus.ifu_rdata, bus.lsu_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_op, bus.mem_we} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.ifu_rdata, bus.lsu_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_op, bus.mem_we}); end
      rst_n = 1; #1;
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin failures++; $display("FAIL first_tie_ready got=%b exp=10", {bus.ifu_req_ready, bus.lsu_req_ready}); end
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin failures++; $display("FAIL first_tie_issue got=%b/%h exp=1/00000100", bus.mem_req_valid, bus.mem_addr); end
   endtask

   task automatic test_ifu_read();
      do_reset();
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000; bus.mem_req_ready = 1; #1;
      checks++; if (bus.ifu_req_ready !== 1'b1) begin failures++; $display("FAIL ifu_accept got=%b exp=1", bus.ifu_req_ready); end
      @(negedge clk);
      bus.ifu_req_valid = 0; bus.ifu_addr = 0;
      checks++; if ({bus.mem_req_valid, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0}) begin failures++; $display("FAIL ifu_issue got=%h exp=%h", {bus.mem_req_valid, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0}); end
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b0 || bus.ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL ifu_wait got=%b%b exp=00", bus.mem_req_valid, bus.ifu_resp_valid); end
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_0413;
      @(negedge clk);
      bus.mem_resp_valid = 0; bus.mem_rdata = 0;
      checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata} !== {2'b10, 32'h0000_0413}) begin failures++; $display("FAIL ifu_resp got=%h exp=%h", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_rdata}, {2'b10, 32'h0000_0413}); end
      @(negedge clk);
      checks++; if (bus.ifu_resp_valid !== 1'b0 || bus.ifu_rdata !== 32'h0000_0413) begin failures++; $display("FAIL ifu_resp_hold got=%b/%h exp=0/00000413", bus.ifu_resp_valid, bus.ifu_rdata); end
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h1000;
      bus.lsu_req_valid = 1; bus.lsu_addr = 32'h2000; bus.lsu_mem_op = 3'b100; bus.lsu_wdata = 32'h55;
      bus.mem_req_ready = 1; #1;
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin failures++; $display("FAIL rr_tie1 got=%b exp=10", {bus.ifu_req_ready, bus.lsu_req_ready}); end
      @(negedge clk);
      bus.ifu_req_valid = 0; #1;
      checks++; if (bus.lsu_req_ready !== 1'b0 || bus.mem_addr !== 32'h1000) begin failures++; $display("FAIL rr_issue_block got=%b/%h exp=0/00001000", bus.lsu_req_ready, bus.mem_addr); end
      @(negedge clk);
      checks++; if (bus.lsu_req_ready !== 1'b0) begin failures++; $display("FAIL rr_wait_block got=%b exp=0", bus.lsu_req_ready); end
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'hAAAA_0001;
      @(negedge clk);
      bus.mem_resp_valid = 0; bus.ifu_req_valid = 1; bus.ifu_addr = 32'h1004; #1;
      checks++; if ({bus.ifu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 3'b101) begin failures++; $display("FAIL rr_tie2 got=%b exp=101", {bus.ifu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready}); end
      @(negedge clk);
      bus.lsu_req_valid = 0; #1;
      checks++; if ({bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.ifu_req_ready} !== {1'b0, 3'b100, 32'h2000, 32'h55, 1'b0}) begin failures++; $display("FAIL rr_lsu_issue got=%h exp=%h", {bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.ifu_req_ready}, {1'b0, 3'b100, 32'h2000, 32'h55, 1'b0}); end
      @(negedge clk);
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBBBB_0002;
      @(negedge clk);
      bus.mem_resp_valid = 0; #1;
      checks++; if ({bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_rdata, bus.ifu_req_ready} !== {1'b1, 32'hBBBB_0002, 32'hAAAA_0001, 1'b1}) begin failures++; $display("FAIL rr_lsu_resp got=%h exp=%h", {bus.lsu_resp_valid, bus.lsu_rdata, bus.ifu_rdata, bus.ifu_req_ready}, {1'b1, 32'hBBBB_0002, 32'hAAAA_0001, 1'b1}); end
   endtask

   task automatic test_store_stall();
      int pulses = 0;
      int ifu_pulses = 0;
      do_reset();
      bus.lsu_req_valid = 1; bus.lsu_we = 1; bus.lsu_mem_op = 3'b010;
      bus.lsu_addr = 32'h8000_1000; bus.lsu_wdata = 32'hDEAD_BEEF; #1;
      checks++; if (bus.lsu_req_ready !== 1'b1) begin failures++; $display("FAIL st_accept got=%b exp=1", bus.lsu_req_ready); end
      @(negedge clk);
      bus.lsu_req_valid = 0; bus.lsu_we = 0; bus.lsu_mem_op = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({bus.mem_req_valid, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 3'b010, 32'h8000_1000, 32'hDEAD_BEEF}) begin failures++; $display("FAIL st_stable%0d got=%h exp=%h", i, {bus.mem_req_valid, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 3'b010, 32'h8000_1000, 32'hDEAD_BEEF}); end
         if (i == 3) bus.mem_req_ready = 1;
         @(negedge clk);
      end
      bus.mem_req_ready = 0;
      checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL st_wait got=%b exp=0", bus.mem_req_valid); end
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.mem_resp_valid = 0;
      for (int i = 0; i < 4; i++) begin
         pulses += int'(bus.lsu_resp_valid);
         ifu_pulses += int'(bus.ifu_resp_valid);
         @(negedge clk);
      end
      checks++; if (pulses != 1 || ifu_pulses != 0) begin failures++; $display("FAIL st_ack_pulses got=%0d/%0d exp=1/0", pulses, ifu_pulses); end
   endtask

   task automatic test_spurious();
      int pulses = 0;
      do_reset();
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pulses += int'(bus.ifu_resp_valid) + int'(bus.lsu_resp_valid);
      end
      checks++; if (pulses != 0 || bus.ifu_rdata !== 32'h0 || bus.lsu_rdata !== 32'h0) begin failures++; $display("FAIL spur_idle got=%0d/%h/%h exp=0/0/0", pulses, bus.ifu_rdata, bus.lsu_rdata); end
      bus.mem_resp_valid = 0; bus.ifu_req_valid = 1; bus.ifu_addr = 32'h40;
      @(negedge clk);
      bus.ifu_req_valid = 0; bus.mem_resp_valid = 1;
      @(negedge clk);
      pulses += int'(bus.ifu_resp_valid) + int'(bus.lsu_resp_valid);
      bus.mem_resp_valid = 0; bus.mem_req_ready = 1;
      @(negedge clk);
      pulses += int'(bus.ifu_resp_valid) + int'(bus.lsu_resp_valid);
      bus.mem_req_ready = 0;
      checks++; if (pulses != 0 || bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL spur_issue got=%0d/%b exp=0/0", pulses, bus.mem_req_valid); end
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'h77;
      @(negedge clk);
      bus.mem_resp_valid = 0;
      checks++; if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_rdata !== 32'h77) begin failures++; $display("FAIL spur_real got=%b/%h exp=1/00000077", bus.ifu_resp_valid, bus.ifu_rdata); end
   endtask

   task automatic test_reset_in_wait();
      int pulses = 0;
      do_reset();
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h200; bus.mem_req_ready = 1;
      @(negedge clk);
      bus.ifu_req_valid = 0;
      @(negedge clk);
      bus.mem_resp_valid = 1; bus.mem_rdata = 32'hCAFE_0001;
      @(negedge clk);
      bus.mem_resp_valid = 0; bus.ifu_req_valid = 1; bus.ifu_addr = 32'h204; #1;
      checks++; if ({bus.ifu_resp_valid, bus.ifu_req_ready, bus.ifu_rdata} !== {2'b11, 32'hCAFE_0001}) begin failures++; $display("FAIL rw_same_cycle got=%h exp=%h", {bus.ifu_resp_valid, bus.ifu_req_ready, bus.ifu_rdata}, {2'b11, 32'hCAFE_0001}); end
      @(negedge clk);
      bus.ifu_req_valid = 0;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'h204) begin failures++; $display("FAIL rw_in_wait got=%b/%h exp=0/00000204", bus.mem_req_valid, bus.mem_addr); end
      rst_n = 0; bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; #1;
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 5'b0) begin failures++; $display("FAIL rw_flags got=%b exp=00000", {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid}); end
      checks++; if (bus.ifu_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rw_data got=%h/%h exp=0/0", bus.ifu_rdata, bus.mem_addr); end
      @(negedge clk);
      rst_n = 1; bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_resp_valid = 0;
         pulses += int'(bus.ifu_resp_valid) + int'(bus.lsu_resp_valid);
      end
      checks++; if (pulses != 0 || bus.ifu_rdata !== 32'h0) begin failures++; $display("FAIL rw_late_resp got=%0d/%h exp=0/0", pulses, bus.ifu_rdata); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ifu_read();
      test_round_robin();
      test_store_stall();
      test_spurious();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
